uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive buffer depth in bytes; power of two, at least 2.
REQ-004 SHALL have port clk_sys, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_sys_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port RX, input, 1, asynchronous UART line; idles high.
REQ-007 SHALL have port rx_data, output, 8, byte at the FIFO head.
REQ-008 SHALL have port rx_valid, output, 1, FIFO not empty.
REQ-009 SHALL have port rx_ready, input, 1, consumer pop request.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH+1), current occupancy.

Function
REQ-013 SHALL pass RX through a 2-flop synchronizer reset to 1 before any use.
REQ-014 SHALL generate a 16x oversample tick every DIV clocks, where DIV = round(CLK_FREQ_HZ/(16*BAUD)) with a minimum of 1.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
- IDLE→START: on a synchronized falling edge; the tick counter restarts at 0.
REQ-016 SHALL decide START at tick 8.
- Majority sample low → DATA.
- Otherwise → IDLE (glitch rejected; nothing pushed, no error).
REQ-017 SHALL sample each data bit by 3-sample majority at ticks 7, 8, 9 of the bit; 8 bits, LSB first.
REQ-018 SHALL evaluate the stop bit by majority at tick 8 of STOP.
- High: push byte, → IDLE.
- Low: pulse frame_err, discard byte, → WAIT_HIGH.
REQ-019 SHALL hold WAIT_HIGH until the synchronized RX is high, then → IDLE; a break condition produces exactly one frame_err.
REQ-020 SHALL make FIFO output show-ahead: rx_data = head whenever rx_valid=1; a pop occurs when rx_valid && rx_ready.
REQ-021 SHALL, on a push while full with no pop that cycle, drop the new byte, pulse overrun, and leave contents unchanged.
REQ-022 SHALL, on simultaneous push and pop while full, accept both, leaving level at FIFO_DEPTH with no overrun.
REQ-023 SHALL, on simultaneous push and pop while empty, push only; rx_valid stays 0 that cycle.
REQ-024 SHALL leave rx_data undefined-but-stable (last head) while rx_valid=0 and ignore rx_ready.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-026 SHALL make the latency from the stop-bit tick-8 sample to rx_valid rising (empty FIFO) exactly 1 clock.

Reset
REQ-027 SHALL, on asserting rst_sys_n low, immediately force the FSM to IDLE and clear the tick/bit counters, FIFO pointers and level, rx_valid, frame_err and overrun; synchronizer flops go to 1.
REQ-028 SHALL abandon a frame in progress on reset mid-frame, with no push and no error; reception restarts on the next falling edge after release.

Structure
REQ-029 SHALL place the FSM state enum, the DIV computation function and the oversample constant 16 in the shared package uart_pkg.
REQ-030 SHALL implement the buffer as sub-module sync_fifo (parameters WIDTH, DEPTH), reusable by the TX path.

Verification (CLK_FREQ_HZ=16_000_000, BAUD=1_000_000, DIV=1, 16 clk/bit, FIFO_DEPTH=4)
REQ-031 SHALL cover: frame 0x55 with rx_ready=0 → rx_valid=1, rx_data=0x55, fifo_level=1, no error pulses.
REQ-032 SHALL cover: 4-clock low glitch on idle RX → no push, FSM back in IDLE, no frame_err.
REQ-033 SHALL cover: frame 0xA3 with low stop bit, RX held low 40 bits then high → one frame_err pulse, fifo_level unchanged, next frame 0x3C received.
REQ-034 SHALL cover: 5 frames 0x01..0x05 with rx_ready=0 → level 4, one overrun on the 5th, pops return 0x01..0x04.
REQ-035 SHALL cover: FIFO full with rx_ready=1 held at the 5th push → no overrun, level stays 4.
REQ-036 SHALL cover: rst_sys_n low during data bit 4 of 0xFF → no push; subsequent 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, oversample ratio,
// and the baud-divider computation used by the RX (and later TX) paths.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        int unsigned d;
        d = (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Show-ahead byte stream with occupancy.
//   master: producer side (drives data, valid, level; receives ready)
//   slave : consumer side (receives data, valid, level; drives ready)
interface uart_rx_fifo_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LEVEL_W = 5
);
    logic [WIDTH-1:0]   data;
    logic               valid;
    logic               ready;
    logic [LEVEL_W-1:0] level;

    modport master (output data, output valid, output level, input ready);
    modport slave  (input data, input valid, input level, output ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : write request, push_data_i: write data
//   overflow_o   : one-cycle pulse when a push is dropped (full, no pop)
//   pop_if       : head data / not-empty / occupancy out, pop request in
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             overflow_o,
    uart_rx_fifo_if.master   pop_if
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    // Pop only when something is there; a full FIFO still accepts a push
    // in the same cycle it is popped.
    assign pop     = !empty && pop_if.ready;
    assign push_ok = push_i && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            overflow_q <= push_i && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_if.data  = mem_q[rd_ptr_q];
    assign pop_if.valid = !empty;
    assign pop_if.level = level_q;
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver (8N1) feeding a show-ahead FIFO.
//   clk_sys, rst_sys_n : clock, async active-low reset
//   RX                 : asynchronous serial line, idles high
//   rx_data/rx_valid   : FIFO head and not-empty; rx_ready pops
//   frame_err          : pulse when the stop bit samples low
//   overrun            : pulse when a received byte is dropped (FIFO full)
//   fifo_level         : current FIFO occupancy
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                               clk_sys,
    input  logic                               rst_sys_n,
    input  logic                               RX,
    output logic [7:0]                         rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic                               frame_err,
    output logic                               overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
    localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    rx_state_e        state_q, state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [1:0]       samp_q, samp_d;
    logic             frame_err_q, frame_err_d;
    logic             tick, fall, maj, push;

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));
    assign fall = rx_prev_q && !rx_sync_q;
    // Majority of the two previous tick samples and the current one.
    assign maj  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync_q) |
                  (samp_q[0] & rx_sync_q);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        samp_d      = samp_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        if (tick) begin
            samp_d     = {samp_q[0], rx_sync_q};
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            // Decision at tick 8, but the bit only ends at tick 15 so the
            // first data bit is sampled in its own bit period.
            START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd8 && maj) begin
                        state_d = IDLE;
                    end else if (tick_cnt_q == 4'd15) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd9) shreg_d = {maj, shreg_q[7:1]};
                    if (tick_cnt_q == 4'd15) begin
                        if (bit_cnt_q == 3'd7) state_d   = STOP;
                        else                   bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick && tick_cnt_q == 4'd8) begin
                    if (maj) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            div_cnt_q   <= '0;
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            samp_q      <= '1;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= RX;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            samp_q      <= samp_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo_if #(.WIDTH(8), .LEVEL_W($clog2(FIFO_DEPTH+1))) fifo_if ();

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk_sys),
        .rst_n       (rst_sys_n),
        .push_i      (push),
        .push_data_i (shreg_q),
        .overflow_o  (overrun),
        .pop_if      (fifo_if.master)
    );

    assign fifo_if.ready = rx_ready;
    assign rx_data       = fifo_if.data;
    assign rx_valid      = fifo_if.valid;
    assign fifo_level    = fifo_if.level;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit, FIFO depth 4.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 16;

    logic clk_sys = 1'b0;
    logic rst_sys_n;
    logic RX;
    logic frame_err;
    logic overrun;

    int total  = 0;
    int bad    = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_fifo_if #(.WIDTH(8), .LEVEL_W(3)) bus ();

    always #5 clk_sys = ~clk_sys;

    uart_rx_fifo #(
        .CLK_FREQ_HZ (16_000_000),
        .BAUD        (1_000_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .RX         (RX),
        .rx_data    (bus.data),
        .rx_valid   (bus.valid),
        .rx_ready   (bus.ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (bus.level)
    );

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1)   ov_cnt++;
    end

    task automatic drive_bit(input logic b);
        RX = b;
        repeat (BIT_CLKS) @(negedge clk_sys);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        RX = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic pop_one;
        bus.ready = 1'b1;
        @(negedge clk_sys);
        bus.ready = 1'b0;
    endtask

    task automatic test_reset;
        RX = 1'b1;
        bus.ready = 1'b0;
        rst_sys_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst_sys_n = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_single;
        fe_cnt = 0; ov_cnt = 0;
        send_frame(8'h55, 1'b1);
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.valid); end
        total++; if (bus.data !== 8'h55) begin bad++; $display("FAIL single_data: got %h want 55", bus.data); end
        total++; if (bus.level !== 3'd1) begin bad++; $display("FAIL single_level: got %0d want 1", bus.level); end
        total++; if (fe_cnt != 0 || ov_cnt != 0) begin bad++; $display("FAIL single_pulses: got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt); end
        pop_one();
        total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0) begin bad++; $display("FAIL single_pop: got valid=%b level=%0d want 0 0", bus.valid, bus.level); end
        // ready while empty must not disturb the level
        pop_one();
        total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL empty_ready: got level=%0d want 0", bus.level); end
    endtask

    task automatic test_glitch;
        fe_cnt = 0;
        RX = 1'b0;
        repeat (4) @(negedge clk_sys);
        RX = 1'b1;
        repeat (40) @(negedge clk_sys);
        total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0) begin bad++; $display("FAIL glitch_nopush: got valid=%b level=%0d want 0 0", bus.valid, bus.level); end
        total++; if (fe_cnt != 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt); end
        send_frame(8'h5A, 1'b1);
        total++; if (bus.data !== 8'h5A || bus.level !== 3'd1) begin bad++; $display("FAIL glitch_next: got data=%h level=%0d want 5a 1", bus.data, bus.level); end
        pop_one();
    endtask

    task automatic test_frame_err;
        logic [7:0] b;
        b = 8'hA3;
        fe_cnt = 0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        RX = 1'b0;
        repeat (40 * BIT_CLKS) @(negedge clk_sys);
        RX = 1'b1;
        repeat (32) @(negedge clk_sys);
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", fe_cnt); end
        total++; if (bus.level !== 3'd0 || bus.valid !== 1'b0) begin bad++; $display("FAIL ferr_level: got level=%0d valid=%b want 0 0", bus.level, bus.valid); end
        send_frame(8'h3C, 1'b1);
        total++; if (bus.data !== 8'h3C || bus.level !== 3'd1) begin bad++; $display("FAIL ferr_next: got data=%h level=%0d want 3c 1", bus.data, bus.level); end
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL ferr_after: got %0d want 1", fe_cnt); end
        pop_one();
    endtask

    task automatic test_overrun;
        ov_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 4) begin
                total++; if (bus.level !== 3'd4 || ov_cnt != 0) begin bad++; $display("FAIL ovr_fill: got level=%0d ov=%0d want 4 0", bus.level, ov_cnt); end
            end
        end
        total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL ovr_level: got %0d want 4", bus.level); end
        total++; if (ov_cnt != 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", ov_cnt); end
        for (int k = 1; k <= 4; k++) begin
            total++; if (bus.valid !== 1'b1 || bus.data !== 8'(k)) begin bad++; $display("FAIL ovr_pop%0d: got valid=%b data=%h want 1 %h", k, bus.valid, bus.data, 8'(k)); end
            pop_one();
        end
        total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0) begin bad++; $display("FAIL ovr_drained: got valid=%b level=%0d want 0 0", bus.valid, bus.level); end
    endtask

    task automatic test_full_pop;
        logic [7:0] b;
        ov_cnt = 0;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL fullpop_fill: got %0d want 4", bus.level); end
        b = 8'h15;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        // stop bit: ready high for the one cycle ending at the stop-bit decision
        RX = 1'b1;
        repeat (11) @(negedge clk_sys);
        bus.ready = 1'b1;
        @(negedge clk_sys);
        bus.ready = 1'b0;
        repeat (8) @(negedge clk_sys);
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL fullpop_overrun: got %0d want 0", ov_cnt); end
        total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL fullpop_level: got %0d want 4", bus.level); end
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.data !== 8'h12 + 8'(k)) begin bad++; $display("FAIL fullpop_pop%0d: got %h want %h", k, bus.data, 8'h12 + 8'(k)); end
            pop_one();
        end
    endtask

    task automatic test_reset_mid;
        fe_cnt = 0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX = 1'b1;
        repeat (8) @(negedge clk_sys);
        rst_sys_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (8) @(negedge clk_sys);
        total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0) begin bad++; $display("FAIL rstmid_nopush: got valid=%b level=%0d want 0 0", bus.valid, bus.level); end
        total++; if (fe_cnt != 0) begin bad++; $display("FAIL rstmid_ferr: got %0d want 0", fe_cnt); end
        send_frame(8'h81, 1'b1);
        total++; if (bus.data !== 8'h81 || bus.level !== 3'd1) begin bad++; $display("FAIL rstmid_next: got data=%h level=%0d want 81 1", bus.data, bus.level); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
